// File: rtl/asteroid_wave_ctrl.sv
// asteroid_wave_ctrl: game-state controller for a single falling asteroid.
// This block spawns the asteroid at a pseudo-random column and moves it down once per frame.
// It resolves fire (destroy) and planet-impact outcomes and keeps score and lives.
// All coordinates are raw counter space (visible H 144..783, V 36..515).
//
// Ports:
//   clk_i          system clock (50 MHz domain)
//   rst_ni         asynchronous active-low reset
//   frame_tick_i   one-clk pulse per frame, at VCounter wrap
//   fire_sw_i      raw fire switch, asynchronous to clk_i
//   ast_h_o        asteroid left column
//   ast_v_o        asteroid top row
//   ast_active_o   asteroid visible and falling
//   exploding_o    high while the destroy animation runs
//   planet_hit_o   one-clk pulse on planet impact
//   score_o        destroyed count, saturates at 255
//   lives_o        remaining lives
//   game_over_o    high once lives are exhausted, until a restart fire
module asteroid_wave_ctrl #(
  parameter int unsigned Size          = 32,
  parameter int unsigned Speed         = 2,
  parameter int unsigned SpawnV        = 36,
  parameter int unsigned DefenseV      = 380,
  parameter int unsigned PlanetV       = 460,
  parameter int unsigned ExplodeFrames = 30,
  parameter int unsigned StartLives    = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       fire_sw_i,
  output logic [9:0] ast_h_o,
  output logic [9:0] ast_v_o,
  output logic       ast_active_o,
  output logic       exploding_o,
  output logic       planet_hit_o,
  output logic [7:0] score_o,
  output logic [1:0] lives_o,
  output logic       game_over_o
);

  localparam int unsigned CntW     = (ExplodeFrames > 1) ? $clog2(ExplodeFrames) : 1;
  localparam logic [9:0]  HReset   = 10'd144;
  localparam logic [9:0]  HBase    = 10'd176;
  localparam logic [9:0]  LfsrSeed = 10'h2A5;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StFall,
    StExplode,
    StOver
  } state_e;

  // ---------------------------------------------------------------------------
  // Fire input: two-flop synchronizer plus rising-edge detect. The edge pulse is
  // combinational off the flops, so the FSM acts on the 3rd clk after the switch.
  // ---------------------------------------------------------------------------
  logic [1:0] fire_sync_q;
  logic       fire_prev_q;
  logic       fire_rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fire_sync_q <= 2'b00;
      fire_prev_q <= 1'b0;
    end else begin
      fire_sync_q <= {fire_sync_q[0], fire_sw_i};
      fire_prev_q <= fire_sync_q[1];
    end
  end

  assign fire_rise = fire_sync_q[1] & ~fire_prev_q;

  // ---------------------------------------------------------------------------
  // 10-bit Fibonacci LFSR, taps 10 and 7 (primitive), free-running every clk.
  // A non-zero seed keeps it out of the all-zero lock-up state.
  // ---------------------------------------------------------------------------
  logic [9:0] lfsr_q;
  logic [9:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // 176 + 0..511 keeps the whole asteroid inside the visible columns.
  logic [9:0] spawn_h;
  assign spawn_h = HBase + {1'b0, lfsr_q[8:0]};

  // ---------------------------------------------------------------------------
  // Descent arithmetic. Zone tests use the row after this clk's frame step, in
  // 11 bits so the bottom edge can never wrap.
  // ---------------------------------------------------------------------------
  logic [9:0]  ast_v_q;
  logic [9:0]  v_next;
  logic [10:0] bottom;
  logic        in_defense;
  logic        at_planet;

  always_comb begin
    v_next     = frame_tick_i ? (ast_v_q + 10'(Speed)) : ast_v_q;
    bottom     = {1'b0, v_next} + 11'(Size);
    in_defense = (bottom >= 11'(DefenseV));
    at_planet  = (bottom >= 11'(PlanetV));
  end

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs.
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [9:0]      ast_h_q;
  logic            active_q;
  logic            exploding_q;
  logic            hit_q;
  logic [7:0]      score_q;
  logic [1:0]      lives_q;
  logic            over_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      ast_h_q     <= HReset;
      ast_v_q     <= 10'(SpawnV);
      active_q    <= 1'b0;
      exploding_q <= 1'b0;
      hit_q       <= 1'b0;
      score_q     <= 8'd0;
      lives_q     <= 2'(StartLives);
      over_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q <= StSpawn;
        end

        StSpawn: begin
          ast_h_q  <= spawn_h;
          ast_v_q  <= 10'(SpawnV);
          active_q <= 1'b1;
          state_q  <= StFall;
        end

        StFall: begin
          ast_v_q <= v_next;
          // A valid fire takes priority over an impact on the same tick.
          if (fire_rise && in_defense) begin
            active_q    <= 1'b0;
            exploding_q <= 1'b1;
            cnt_q       <= '0;
            if (score_q != 8'hFF) begin
              score_q <= score_q + 8'd1;
            end
            state_q <= StExplode;
          end else if (frame_tick_i && at_planet) begin
            active_q <= 1'b0;
            hit_q    <= 1'b1;
            lives_q  <= lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              over_q  <= 1'b1;
              state_q <= StOver;
            end else begin
              state_q <= StSpawn;
            end
          end
        end

        StExplode: begin
          // Position holds so the animation draws at the kill point.
          if (frame_tick_i) begin
            if (cnt_q == CntW'(ExplodeFrames - 1)) begin
              exploding_q <= 1'b0;
              state_q     <= StSpawn;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end

        StOver: begin
          if (fire_rise) begin
            lives_q <= 2'(StartLives);
            score_q <= 8'd0;
            over_q  <= 1'b0;
            state_q <= StSpawn;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ast_h_o      = ast_h_q;
  assign ast_v_o      = ast_v_q;
  assign ast_active_o = active_q;
  assign exploding_o  = exploding_q;
  assign planet_hit_o = hit_q;
  assign score_o      = score_q;
  assign lives_o      = lives_q;
  assign game_over_o  = over_q;

endmodule
